// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous-read framebuffer SRAM
// between the display scan-out fetch (high priority) and an APB slave port.
// A starvation counter lets a waiting APB access take priority once it has
// been held off for STARVE_MAX consecutive cycles.
module vga_fb_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 24,
   parameter int STARVE_MAX = 8
) (
   input  logic              clock,
   input  logic              reset,
   // APB slave
   input  logic [31:0]       in_paddr,
   input  logic              in_psel,
   input  logic              in_penable,
   input  logic              in_pwrite,
   input  logic [31:0]       in_pwdata,
   input  logic [3:0]        in_pstrb,
   output logic              in_pready,
   output logic [31:0]       in_prdata,
   output logic              in_pslverr,
   // display fetch
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   // SRAM macro
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_wmask,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int SC_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

   typedef struct packed {
      logic              en;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [2:0]        wmask;
   } mem_req_t;

   state_t          state, state_nx;
   logic [SC_W-1:0] starve_cnt;
   logic            rd_src;       // last cycle's SRAM read belonged to display
   logic            apb_pend;
   logic            apb_misal;
   logic            disp_win;
   logic            apb_win;
   logic            pslverr_nx;
   mem_req_t        mreq;

   // Address/data bits the framebuffer never looks at.
   logic unused_bits;
   assign unused_bits = ^{in_paddr[31:ADDR_W+2], in_pwdata[31:DATA_W], in_pstrb[3]};

   // An APB access only competes for the SRAM while the FSM is idle; once
   // granted, the FSM walks through RD_WAIT/ACK without needing the port.
   assign apb_pend  = in_psel & in_penable & (state == IDLE);
   assign apb_misal = |in_paddr[1:0];
   assign disp_win  = disp_req & (~apb_pend | (starve_cnt < SC_W'(STARVE_MAX)));
   assign apb_win   = apb_pend & ~disp_win;
   assign disp_gnt  = disp_win;

   // SRAM port driven straight from this cycle's winner.
   always_comb begin
      mreq = '0;
      if (disp_win) begin
         mreq.en   = 1'b1;
         mreq.addr = disp_addr;
      end else if (apb_win && !apb_misal) begin
         // an all-zero strobe write is completed on the bus but never touches the array
         mreq.en    = in_pwrite ? (|in_pstrb[2:0]) : 1'b1;
         mreq.we    = in_pwrite;
         mreq.addr  = in_paddr[ADDR_W+1:2];
         mreq.wdata = in_pwdata[DATA_W-1:0];
         mreq.wmask = in_pstrb[2:0];
      end
   end

   assign mem_en    = mreq.en;
   assign mem_we    = mreq.we;
   assign mem_addr  = mreq.addr;
   assign mem_wdata = mreq.wdata;
   assign mem_wmask = mreq.wmask;

   // Read data returns one cycle after the enable; rd_src steers it to display.
   assign disp_rvalid = rd_src;
   assign disp_rdata  = rd_src ? mem_rdata : '0;

   // APB FSM next state and error flag for the upcoming ACK.
   always_comb begin
      state_nx   = state;
      pslverr_nx = 1'b0;
      case (state)
         IDLE: begin
            if (apb_win) begin
               if (apb_misal) begin
                  state_nx   = ACK;
                  pslverr_nx = 1'b1;
               end else if (in_pwrite) begin
                  state_nx = ACK;
               end else begin
                  state_nx = RD_WAIT;
               end
            end
         end
         RD_WAIT: state_nx = ACK;
         ACK:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // APB FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Registered APB response: ready/error for exactly the ACK cycle, read data captured in RD_WAIT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         in_pready  <= 1'b0;
         in_pslverr <= 1'b0;
         in_prdata  <= '0;
      end else begin
         in_pready  <= (state_nx == ACK);
         in_pslverr <= pslverr_nx;
         if (state == RD_WAIT) in_prdata <= {{(32-DATA_W){1'b0}}, mem_rdata};
      end
   end

   // Starvation counter: counts consecutive denied cycles of a pending APB access.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                      starve_cnt <= '0;
      else if (apb_pend && !apb_win)  starve_cnt <= (starve_cnt == SC_W'(STARVE_MAX)) ?
                                                    starve_cnt : starve_cnt + SC_W'(1);
      else                            starve_cnt <= '0;
   end

   // Remember who owns the read data arriving next cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) rd_src <= 1'b0;
      else       rd_src <= disp_win;
   end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port, synchronous-read framebuffer SRAM (24-bit pixels) between two requesters:
  - the display scan-out fetch port (real-time, high priority);
  - the APB slave port (CPU reads and writes).
- Sits between the APB interconnect, the VGA timing/scan-out logic and the framebuffer SRAM macro.
- Replaces direct dual access to the pixel array, so the framebuffer can be mapped to a single-port SRAM.

Parameters:
- ADDR_W, 19, framebuffer word-address width (one pixel per 32-bit word).
- DATA_W, 24, pixel width (8:8:8 RGB).
- STARVE_MAX, 8, consecutive cycles a pending APB access may be denied before it takes priority over display.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_paddr  in  32  APB address; word address = in_paddr[ADDR_W+1:2]
- in_psel  in  1  APB select
- in_penable  in  1  APB enable (access phase)
- in_pwrite  in  1  APB write
- in_pwdata  in  32  APB write data; [23:0] used
- in_pstrb  in  4  APB byte strobes; [2:0] used
- in_pready  out  1  APB ready
- in_prdata  out  32  APB read data; [31:24] always 0
- in_pslverr  out  1  APB error
- disp_req  in  1  display fetch request; held until granted
- disp_addr  in  ADDR_W  display fetch word address
- disp_gnt  out  1  display request accepted this cycle
- disp_rvalid  out  1  disp_rdata valid
- disp_rdata  out  DATA_W  fetched pixel
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_wmask  out  3  SRAM byte write mask
- mem_rdata  in  DATA_W  SRAM read data; valid the cycle after a read enable

Behaviour:
- Reset (async) clears the following to 0: in_pready, in_prdata, in_pslverr, disp_rvalid, disp_rdata, starve_cnt, rd_src. FSM goes to IDLE. Any in-flight APB transfer is dropped; the master re-issues it.
- The SRAM port is driven combinationally from the cycle's grant. At most one access per cycle.
- apb_pend = in_psel & in_penable & (state==IDLE).
- Grant rule, evaluated every cycle:
  - Display wins if disp_req & (~apb_pend | starve_cnt < STARVE_MAX).
  - Otherwise APB wins if apb_pend.
  - Otherwise the port is idle: mem_en=0.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle apb_pend=1 and APB is not granted.
  - Clears when APB is granted or apb_pend=0.
- Display grant:
  - Cycle T: disp_gnt=1, mem_en=1, mem_we=0, mem_addr=disp_addr.
  - Cycle T+1: disp_rvalid=1 and disp_rdata=mem_rdata (combinational path from mem_rdata; registered rd_src selects the destination).
  - Back-to-back grants give one pixel per cycle.
- APB FSM states: IDLE, RD_WAIT, ACK.
  - IDLE, APB granted, misaligned access (in_paddr[1:0]!=0): no SRAM access; go to ACK with pslverr=1.
  - IDLE, APB granted, write: mem_en=1, mem_we=1, mem_wdata=in_pwdata[23:0], mem_wmask=in_pstrb[2:0]; go to ACK. in_pstrb[2:0]==0 asserts mem_en=0 but still completes without error.
  - IDLE, APB granted, read: mem_en=1, mem_we=0; go to RD_WAIT.
  - RD_WAIT: register in_prdata={8'h0, mem_rdata}; go to ACK.
  - ACK: in_pready=1 for exactly one cycle (registered). in_pslverr is 1 only on the error path. Return to IDLE.
- Uncontended latency, access phase starting at cycle T: write ready at T+1, read ready at T+2.
- in_pready=0 in every state except ACK. In-range reads never set pslverr.
- Access-phase signals (address, data, strobes) are sampled only in the grant cycle; the master holds them stable per APB.

Test Plan:
- Reset mid-read (assert reset while in RD_WAIT) -> in_pready, disp_rvalid and starve_cnt are 0 immediately; FSM is IDLE; a re-issued read completes normally.
- APB write to 0x0000_0040, data 0x00AB_CDEF, strobe 0xF, disp_req=0 -> mem_we pulse with mem_addr=0x10 and mask 3'b111; pready at T+1. A following read of 0x40 returns prdata 0x00AB_CDEF with pready at T+2.
- disp_req held continuously with addresses 0..15 -> disp_gnt every cycle; disp_rvalid/disp_rdata follow one cycle later, in order, with no gaps.
- APB read pending while disp_req held continuously -> display granted for 8 cycles; APB granted on cycle 9 (disp_gnt=0 that cycle); starve_cnt then returns to 0.
- APB write to 0x0000_0042 -> no SRAM access; pready=1 and pslverr=1 on the same cycle. Write with in_pstrb=0 -> pready=1, pslverr=0, and SRAM contents are unchanged.
- Partial write with in_pstrb=0x1, data 0x0000_0055, over stored 0x00112233 -> mem_wmask=3'b001; a subsequent read returns 0x0011_2255.
